// File: rtl/md_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mdOp_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdState_t;

  localparam logic [31:0] MD_DIV0_Q = 32'hFFFFFFFF;
  localparam logic [31:0] MD_OVF_Q  = 32'h80000000;

  function automatic logic opIsDiv(mdOp_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic opSignedA(mdOp_t op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic opSignedB(mdOp_t op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide sequencer handshake bundle.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             Start_E;
  logic [2:0]       MdOp_E;
  logic [WIDTH-1:0] SrcA_E;
  logic [WIDTH-1:0] SrcB_E;
  logic             Flush_E;
  logic             Stall_E;
  logic [WIDTH-1:0] MdResult_E;
  logic             MdValid_E;
  logic             Busy;

  modport master (
    output Start_E, MdOp_E, SrcA_E, SrcB_E, Flush_E,
    input  Stall_E, MdResult_E, MdValid_E, Busy
  );

  modport slave (
    input  Start_E, MdOp_E, SrcA_E, SrcB_E, Flush_E,
    output Stall_E, MdResult_E, MdValid_E, Busy
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on unsigned magnitudes.
// accHi:accLo holds the running product, or remainder:quotient for divides.
module muldiv_core #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] accHi,
  output logic [WIDTH-1:0] accLo
);

  logic [WIDTH-1:0] operand;
  logic             divMode;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  // One iteration's arithmetic: conditional add for multiply, trial subtract for divide
  always_comb begin
    addend = accLo[0] ? operand : '0;
    sum    = {1'b0, accHi} + {1'b0, addend};
    trial  = {accHi, accLo[WIDTH-1]} - {1'b0, operand};
  end

  // Load operands, then advance one bit per step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand <= '0;
      divMode <= 1'b0;
      accHi   <= '0;
      accLo   <= '0;
    end else if (load) begin
      divMode <= isDiv;
      operand <= isDiv ? opB : opA;
      accHi   <= '0;
      accLo   <= isDiv ? opA : opB;
    end else if (step) begin
      if (divMode) begin
        if (!trial[WIDTH]) begin
          accHi <= trial[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], 1'b1};
        end else begin
          accHi <= {accHi[WIDTH-2:0], accLo[WIDTH-1]};
          accLo <= {accLo[WIDTH-2:0], 1'b0};
        end
      end else begin
        accHi <= sum[WIDTH:1];
        accLo <= {sum[0], accLo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: FSM, iteration counter, special cases and sign fix-up.
module muldiv_ctrl
  import md_pkg::*;
#(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rst,
  muldiv_ctrl_if.slave   md
);

  localparam int CW = $clog2(WIDTH);

  mdState_t         state;
  mdOp_t            op;
  mdOp_t            opIn;
  logic [CW-1:0]    cnt;
  logic             negQ;
  logic             negR;
  logic             special;
  logic [WIDTH-1:0] specQ;
  logic [WIDTH-1:0] specR;
  logic             validReg;
  logic             busyReg;

  logic             sA, sB, div0, ovf, accept;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] accHi, accLo;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quoFix, remFix;

  // Operand conditioning, special-case detection and combinational stall
  always_comb begin
    opIn   = mdOp_t'(md.MdOp_E);
    sA     = opSignedA(opIn) & md.SrcA_E[WIDTH-1];
    sB     = opSignedB(opIn) & md.SrcB_E[WIDTH-1];
    absA   = sA ? ('0 - md.SrcA_E) : md.SrcA_E;
    absB   = sB ? ('0 - md.SrcB_E) : md.SrcB_E;
    div0   = opIsDiv(opIn) && (md.SrcB_E == '0);
    ovf    = (opIn == MD_DIV || opIn == MD_REM) &&
             (md.SrcA_E == WIDTH'(MD_OVF_Q)) && (md.SrcB_E == '1);
    accept = (state == MD_IDLE) && md.Start_E && !md.Flush_E;
    md.Stall_E = accept || (state == MD_BUSY);
  end

  muldiv_core #(.WIDTH(WIDTH)) core (
    .clk   (clk),
    .rst   (rst),
    .load  (accept && !(div0 || ovf)),
    .step  ((state == MD_BUSY) && !md.Flush_E),
    .isDiv (opIsDiv(opIn)),
    .opA   (absA),
    .opB   (absB),
    .accHi (accHi),
    .accLo (accLo)
  );

  // Sequencer FSM with registered strobe and busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MD_IDLE;
      op       <= MD_MUL;
      cnt      <= '0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      special  <= 1'b0;
      specQ    <= '0;
      specR    <= '0;
      validReg <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          validReg <= 1'b0;
          if (accept) begin
            op      <= opIn;
            negQ    <= sA ^ sB;
            negR    <= sA;
            busyReg <= 1'b1;
            if (div0 || ovf) begin
              special  <= 1'b1;
              specQ    <= div0 ? WIDTH'(MD_DIV0_Q) : WIDTH'(MD_OVF_Q);
              specR    <= div0 ? md.SrcA_E : '0;
              validReg <= 1'b1;
              state    <= MD_DONE;
            end else begin
              special <= 1'b0;
              cnt     <= CW'(WIDTH - 1);
              state   <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (md.Flush_E) begin
            busyReg <= 1'b0;
            state   <= MD_IDLE;
          end else if (cnt == '0) begin
            validReg <= 1'b1;
            state    <= MD_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MD_DONE: begin
          validReg <= 1'b0;
          busyReg  <= 1'b0;
          state    <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Sign correction and word selection, presented only in DONE
  always_comb begin
    prodFix = negQ ? ('0 - {accHi, accLo}) : {accHi, accLo};
    quoFix  = negQ ? ('0 - accLo) : accLo;
    remFix  = negR ? ('0 - accHi) : accHi;
    md.MdResult_E = '0;
    if (state == MD_DONE) begin
      if (special) begin
        md.MdResult_E = (op == MD_REM || op == MD_REMU) ? specR : specQ;
      end else begin
        unique case (op)
          MD_MUL:                      md.MdResult_E = prodFix[WIDTH-1:0];
          MD_MULH, MD_MULHSU, MD_MULHU: md.MdResult_E = prodFix[2*WIDTH-1:WIDTH];
          MD_DIV, MD_DIVU:             md.MdResult_E = quoFix;
          default:                     md.MdResult_E = remFix;
        endcase
      end
    end
  end

  assign md.MdValid_E = validReg;
  assign md.Busy      = busyReg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, random ops vs. arithmetic model,
// flush/reset/back-to-back sequences.
module tb_muldiv_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_ctrl_if #(.WIDTH(WIDTH)) mdIf();

  muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mdIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result computed directly from RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return WIDTH + 1;
  endfunction

  // Issue one op, hold Start_E while stalled, and check stall span, latency and result
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int expLat, input string name,
                       input bit tail);
    int stalls;
    int lat;
    @(posedge clk); #1;
    mdIf.Start_E = 1'b1;
    mdIf.MdOp_E  = op;
    mdIf.SrcA_E  = a;
    mdIf.SrcB_E  = b;
    mdIf.Flush_E = 1'b0;
    #1;
    check({name, " stall_t"}, 32'(mdIf.Stall_E), 32'd1);
    stalls = 1;
    lat    = 0;
    for (int k = 1; k <= WIDTH + 5; k++) begin
      @(posedge clk); #2;
      if (mdIf.MdValid_E) begin
        lat = k;
        break;
      end
      if (mdIf.Stall_E) stalls++;
    end
    check({name, " latency"}, 32'(lat), 32'(expLat));
    check({name, " result"}, mdIf.MdResult_E, exp);
    check({name, " stall_cycles"}, 32'(stalls), 32'(expLat));
    check({name, " stall_done"}, 32'(mdIf.Stall_E), 32'd0);
    mdIf.Start_E = 1'b0;
    if (tail) begin
      @(posedge clk); #2;
      check({name, " valid_1cyc"}, 32'(mdIf.MdValid_E), 32'd0);
      check({name, " idle_busy"}, 32'(mdIf.Busy), 32'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int gotValid;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "MUL 7*-3"});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "MULHU max"});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "MULH min*min"});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "MULHSU -1*2"});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "MULH -1*-1"});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "DIV -7/2"});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "REM -7%2"});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       1'b0, "DIVU 100/7"});
    vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        1'b0, "REMU 100%7"});
    vecs.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "DIVU min/max"});
    vecs.push_back('{3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, "DIVU /0"});
    vecs.push_back('{3'd6, 32'd100,      32'd0,        32'd100,      1'b1, "REM %0"});
    vecs.push_back('{3'd4, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, "DIV /0"});
    vecs.push_back('{3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, "REMU %0"});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "DIV ovf"});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "REM ovf"});

    mdIf.Start_E = 1'b0;
    mdIf.MdOp_E  = '0;
    mdIf.SrcA_E  = '0;
    mdIf.SrcB_E  = '0;
    mdIf.Flush_E = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("reset stall",  32'(mdIf.Stall_E),   32'd0);
    check("reset valid",  32'(mdIf.MdValid_E), 32'd0);
    check("reset result", mdIf.MdResult_E,     32'd0);
    check("reset busy",   32'(mdIf.Busy),      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed table
    foreach (vecs[i])
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
            vecs[i].spec ? 1 : WIDTH + 1, vecs[i].name, 1'b1);

    // Flush in IDLE together with Start_E: nothing is accepted
    @(posedge clk); #1;
    mdIf.Start_E = 1'b1; mdIf.MdOp_E = 3'd0; mdIf.SrcA_E = 32'd5; mdIf.SrcB_E = 32'd6;
    mdIf.Flush_E = 1'b1;
    #1;
    check("flush idle stall", 32'(mdIf.Stall_E), 32'd0);
    @(posedge clk); #1;
    mdIf.Start_E = 1'b0; mdIf.Flush_E = 1'b0;
    #1;
    check("flush idle busy", 32'(mdIf.Busy), 32'd0);

    // Flush in the 10th BUSY cycle aborts with no strobe
    @(posedge clk); #1;
    mdIf.Start_E = 1'b1; mdIf.MdOp_E = 3'd0; mdIf.SrcA_E = 32'd5; mdIf.SrcB_E = 32'd6;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    mdIf.Flush_E = 1'b1;
    mdIf.Start_E = 1'b0;
    #1;
    check("flush busy stall", 32'(mdIf.Stall_E), 32'd1);
    @(posedge clk); #1;
    mdIf.Flush_E = 1'b0;
    #1;
    check("flush after busy",  32'(mdIf.Busy),      32'd0);
    check("flush after stall", 32'(mdIf.Stall_E),   32'd0);
    gotValid = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      if (mdIf.MdValid_E) gotValid++;
      @(posedge clk); #2;
    end
    check("flush no valid", 32'(gotValid), 32'd0);
    runOp(3'd0, 32'd3, 32'd4, 32'd12, WIDTH + 1, "MUL 3*4 post-flush", 1'b1);

    // Asynchronous reset mid-BUSY clears everything immediately
    @(posedge clk); #1;
    mdIf.Start_E = 1'b1; mdIf.MdOp_E = 3'd5; mdIf.SrcA_E = 32'hDEADBEEF; mdIf.SrcB_E = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    mdIf.Start_E = 1'b0;
    rst = 1'b0;
    #1;
    check("rst mid busy",   32'(mdIf.Busy),      32'd0);
    check("rst mid stall",  32'(mdIf.Stall_E),   32'd0);
    check("rst mid valid",  32'(mdIf.MdValid_E), 32'd0);
    check("rst mid result", mdIf.MdResult_E,     32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back: second Start_E lands in the cycle right after DONE
    runOp(3'd0, 32'd2, 32'd9 - 32'd6, 32'd6, WIDTH + 1, "b2b MUL 2*3", 1'b0);
    runOp(3'd5, 32'd9, 32'd3,         32'd3, WIDTH + 1, "b2b DIVU 9/3", 1'b1);

    // Random ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 15))
        0, 1: rb = '0;
        2:    begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3:    rb = 32'($urandom_range(1, 15));
        4:    ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      runOp(rop, ra, rb, refModel(rop, ra, rb), refLatency(rop, ra, rb),
            $sformatf("rand%0d op%0d %h %h", n, rop, ra, rb), 1'b0);
    end

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
